// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: slot count, pattern modes, fixed pattern constants
// and the step-index to pin-pattern decode.
package gpio_pkg;

    localparam int unsigned GPIO_COUNT = 32;
    localparam int unsigned SEQ_W      = 7;

    typedef enum logic [1:0] {
        WALK1 = 2'd0,
        WALK0 = 2'd1,
        CHECK = 2'd2,
        BLINK = 2'd3
    } gpio_mode_t;

    localparam logic [GPIO_COUNT-1:0] PAT_CHECK_ODD  = 32'hAAAA_AAAA;
    localparam logic [GPIO_COUNT-1:0] PAT_CHECK_EVEN = 32'h5555_5555;

    // seq = {mode[1:0], idx[4:0]}; purely combinational
    function automatic logic [GPIO_COUNT-1:0] gpio_pattern(input logic [SEQ_W-1:0] s);
        gpio_mode_t            mode;
        logic [4:0]            idx;
        logic [GPIO_COUNT-1:0] one_hot;
        logic [GPIO_COUNT-1:0] pat;
        mode         = gpio_mode_t'(s[6:5]);
        idx          = s[4:0];
        one_hot      = '0;
        one_hot[idx] = 1'b1;
        pat          = '0;
        case (mode)
            WALK1:   pat = one_hot;
            WALK0:   pat = ~one_hot;
            CHECK:   pat = idx[0] ? PAT_CHECK_ODD : PAT_CHECK_EVEN;
            BLINK:   pat = idx[0] ? '1 : '0;
            default: pat = '0;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/gpio_tick_div.sv
// Step-rate prescaler: counts 0..DIV-1 and flags the terminal count as tick.
// hold freezes the count and suppresses tick.
module gpio_tick_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    output logic tick
);

    localparam int unsigned     CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_comb begin
        tick = (cnt == CNT_MAX) && !hold;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!hold) begin
            if (cnt == CNT_MAX) cnt <= '0;
            else                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_pattern_seq.sv
// GPIO pattern sequencer: steps a 7-bit index at STEP_HZ and drives the decoded
// 32-bit pattern. Define GPIO_PAUSE_EN to add the pause input.
module gpio_pattern_seq
    import gpio_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 12_000_000,
    parameter int unsigned STEP_HZ = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef GPIO_PAUSE_EN
    input  logic                  pause,
`endif
    output logic [GPIO_COUNT-1:0] gpio_out,
    output logic [SEQ_W-1:0]      seq,
    output logic                  step
);

    localparam int unsigned DIV = CLK_HZ / STEP_HZ;

    logic hold;
    logic tick;

    always_comb begin
`ifdef GPIO_PAUSE_EN
        hold = pause;
`else
        hold = 1'b0;
`endif
    end

    gpio_tick_div #(
        .DIV (DIV)
    ) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (hold),
        .tick  (tick)
    );

    // gpio_out decodes the pre-edge seq, giving exactly one cycle of latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seq      <= '0;
            step     <= 1'b0;
            gpio_out <= '0;
        end else begin
            step     <= tick;
            gpio_out <= gpio_pattern(seq);
            if (tick) seq <= seq + 7'd1;
        end
    end

endmodule

// File: tb/tb_gpio_pattern_seq.sv
// Self-checking bench for gpio_pattern_seq (CLK_HZ=16, STEP_HZ=4) against a
// cycle-count reference model; pause checks run when GPIO_PAUSE_EN is defined.
module tb_gpio_pattern_seq;

    localparam int unsigned DIV = 4;
`ifdef GPIO_PAUSE_EN
    localparam bit PAUSE_BUILT = 1'b1;
`else
    localparam bit PAUSE_BUILT = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
`ifdef GPIO_PAUSE_EN
    logic        pause;
`endif
    logic [31:0] gpio_out;
    logic [6:0]  seq;
    logic        step;

    int unsigned n_tests;
    int unsigned n_fail;

    // reference model state: active (non-reset, non-paused) edges since reset
    int unsigned m_n;
    logic [6:0]  m_seq;
    logic        m_step;
    logic [31:0] m_gpio;

    gpio_pattern_seq #(
        .CLK_HZ  (16),
        .STEP_HZ (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef GPIO_PAUSE_EN
        .pause    (pause),
`endif
        .gpio_out (gpio_out),
        .seq      (seq),
        .step     (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_pattern(input int unsigned s);
        int unsigned mode;
        int unsigned idx;
        logic [31:0] b;
        mode   = s / 32;
        idx    = s % 32;
        b      = 32'h0;
        b[idx] = 1'b1;
        case (mode)
            0:       return b;
            1:       return ~b;
            2:       return (idx % 2 == 1) ? 32'hAAAA_AAAA : 32'h5555_5555;
            default: return (idx % 2 == 1) ? 32'hFFFF_FFFF : 32'h0000_0000;
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic p);
        logic p_eff;
        p_eff = p & PAUSE_BUILT;
        if (!r) begin
            m_n    = 0;
            m_seq  = 7'd0;
            m_step = 1'b0;
            m_gpio = 32'h0;
        end else begin
            m_gpio = ref_pattern(int'(m_seq));
            if (p_eff) begin
                m_step = 1'b0;
            end else begin
                m_n++;
                m_seq  = 7'((m_n / DIV) % 128);
                m_step = (m_n % DIV) == 0;
            end
        end
    endtask

    task automatic run_cycle(input logic r, input logic p);
        rst_n = r;
`ifdef GPIO_PAUSE_EN
        pause = p;
`endif
        @(posedge clk);
        model_edge(r, p);
        #1;
        check("seq", {25'd0, seq}, {25'd0, m_seq});
        check("step", {31'd0, step}, {31'd0, m_step});
        check("gpio_out", gpio_out, m_gpio);
    endtask

    // run until the step edge that shows target, then one more cycle so gpio_out follows
    task automatic run_to(input logic [6:0] target, input string tag);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            run_cycle(1'b1, 1'b0);
            if (step && seq == target) begin
                found = 1'b1;
                break;
            end
        end
        if (found) run_cycle(1'b1, 1'b0);
        else       check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int unsigned pulses;
        int unsigned last_step;
        int unsigned lat;
        bit          r;
        bit          p;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
`ifdef GPIO_PAUSE_EN
        pause   = 1'b0;
`endif

        // reset for 3 cycles, then release
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0);
        check("rst_gpio", gpio_out, 32'h0);
        check("rst_seq", {25'd0, seq}, 32'd0);
        run_cycle(1'b1, 1'b0);
        check("first_gpio", gpio_out, 32'h1);
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0);
        check("first_step", {31'd0, step}, 32'd1);
        check("first_seq", {25'd0, seq}, 32'd1);
        run_cycle(1'b1, 1'b0);
        check("first_gpio2", gpio_out, 32'h2);

        // sweep boundaries
        run_to(7'd31, "walk1_31");
        check("walk1_31", gpio_out, 32'h8000_0000);
        run_to(7'd32, "walk0_0");
        check("walk0_0", gpio_out, 32'hFFFF_FFFE);
        run_to(7'd65, "check_1");
        check("check_1", gpio_out, 32'hAAAA_AAAA);
        run_to(7'd97, "blink_1");
        check("blink_1", gpio_out, 32'hFFFF_FFFF);
        run_to(7'd0, "wrap");
        check("wrap_gpio", gpio_out, 32'h1);

        // step pulse width and period over 512 cycles
        pulses    = 0;
        last_step = 0;
        for (int unsigned i = 1; i <= 512; i++) begin
            run_cycle(1'b1, 1'b0);
            if (step) begin
                if (pulses > 0) check("step_period", i - last_step, DIV);
                pulses++;
                last_step = i;
            end
        end
        check("step_count", pulses, 128);

        // reset mid-step at cnt = 2, seq = 40
        run_to(7'd40, "mid_seq40");
        run_cycle(1'b1, 1'b0);
        run_cycle(1'b0, 1'b0);
        check("mid_rst_seq", {25'd0, seq}, 32'd0);
        check("mid_rst_gpio", gpio_out, 32'h0);
        lat = 0;
        for (int unsigned i = 1; i <= 20; i++) begin
            run_cycle(1'b1, 1'b0);
            if (step) begin
                lat = i;
                break;
            end
        end
        check("mid_rst_latency", lat, DIV);

`ifdef GPIO_PAUSE_EN
        // pause over the tick cycle for 10 cycles
        run_to(7'd10, "pause_seq10");
        run_cycle(1'b1, 1'b0);
        run_cycle(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            run_cycle(1'b1, 1'b1);
            check("pause_seq", {25'd0, seq}, 32'd10);
            check("pause_step", {31'd0, step}, 32'd0);
            check("pause_gpio", gpio_out, ref_pattern(10));
        end
        run_cycle(1'b1, 1'b0);
        check("resume_step", {31'd0, step}, 32'd1);
        check("resume_seq", {25'd0, seq}, 32'd11);
`endif

        // randomized reset / pause activity against the model
        r = 1'b1;
        p = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 7) == 0) p = ~p;
            run_cycle(r, p);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
